// File: rtl/rf_banked_bypass.sv
// Banked physical register file: one write port per bank, N_RD registered read
// ports with same-cycle write bypass, post-reset hardware clear, sticky bank errors.
module rf_banked_bypass #(
  parameter int WIDTH    = 64,
  parameter int LG_DEPTH = 7,
  parameter int LG_BANKS = 1,
  parameter int N_RD     = 6,
  localparam int N_BANKS = 1 << LG_BANKS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_RD*LG_DEPTH-1:0]    rdptr,
  output logic [N_RD*WIDTH-1:0]       rd,
  input  logic [N_BANKS-1:0]          wen,
  input  logic [N_BANKS*LG_DEPTH-1:0] wrptr,
  input  logic [N_BANKS*WIDTH-1:0]    wr,
  output logic                        init_done,
  output logic [N_BANKS-1:0]          bank_err
);

  localparam int IDX_W      = LG_DEPTH - LG_BANKS;
  localparam int BANK_DEPTH = 1 << IDX_W;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_init_done;
  logic [N_BANKS-1:0]    r_bank_err;
  logic [N_BANKS-1:0]    w_wr_legal;
  logic [N_BANKS-1:0]    w_wr_ok;
  logic [N_RD-1:0]       w_hit;
  logic [WIDTH-1:0]      w_byp [N_RD];
  logic [N_RD*WIDTH-1:0] w_rd_nxt;
  logic [N_RD*WIDTH-1:0] r_rd;
  logic [WIDTH-1:0]      r_mem [N_BANKS][BANK_DEPTH];

  // Clear-sequence FSM: walk every bank index once, then park in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        w_cnt_nxt = r_cnt + IDX_W'(1);
        if (r_cnt == IDX_W'(BANK_DEPTH - 1)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // FSM state, clear counter and done flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_done <= (w_state_nxt == ST_RUN);
    end
  end

  // A bank port may only target its own bank; pointer 0 is never stored.
  always_comb begin
    w_wr_legal = '0;
    w_wr_ok    = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      w_wr_legal[b] = (wrptr[b*LG_DEPTH + LG_DEPTH - 1 -: LG_BANKS] == LG_BANKS'(b));
      w_wr_ok[b]    = wen[b] && w_wr_legal[b] && (r_state == ST_RUN) &&
                      (wrptr[b*LG_DEPTH +: LG_DEPTH] != '0);
    end
  end

  // Bypass select: at most one bank port can match a given read pointer.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_RD; i++) begin
      w_byp[i] = '0;
      for (int b = 0; b < N_BANKS; b++) begin
        w_hit[i] = w_hit[i] |
                   (w_wr_ok[b] && (wrptr[b*LG_DEPTH +: LG_DEPTH] == rdptr[i*LG_DEPTH +: LG_DEPTH]));
        w_byp[i] = w_byp[i] |
                   ({WIDTH{w_wr_ok[b] && (wrptr[b*LG_DEPTH +: LG_DEPTH] == rdptr[i*LG_DEPTH +: LG_DEPTH])}}
                    & wr[b*WIDTH +: WIDTH]);
      end
    end
  end

  // Next read data: zero in INIT or for pointer 0, else bypass, else storage.
  always_comb begin
    w_rd_nxt = '0;
    for (int i = 0; i < N_RD; i++) begin
      if ((r_state != ST_RUN) || (rdptr[i*LG_DEPTH +: LG_DEPTH] == '0)) begin
        w_rd_nxt[i*WIDTH +: WIDTH] = '0;
      end else if (w_hit[i]) begin
        w_rd_nxt[i*WIDTH +: WIDTH] = w_byp[i];
      end else begin
        w_rd_nxt[i*WIDTH +: WIDTH] =
          r_mem[rdptr[i*LG_DEPTH + LG_DEPTH - 1 -: LG_BANKS]][rdptr[i*LG_DEPTH +: IDX_W]];
      end
    end
  end

  // Storage: cleared one index per cycle in INIT, written by legal ports in RUN.
  always_ff @(posedge clk) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (r_state == ST_INIT) begin
        r_mem[b][r_cnt] <= '0;
      end else if (w_wr_ok[b]) begin
        r_mem[b][wrptr[b*LG_DEPTH +: IDX_W]] <= wr[b*WIDTH +: WIDTH];
      end
    end
  end

  // Registered read data and sticky bank-violation flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd       <= '0;
      r_bank_err <= '0;
    end else begin
      r_rd <= w_rd_nxt;
      if (r_state == ST_RUN) begin
        r_bank_err <= r_bank_err | (wen & ~w_wr_legal);
      end
    end
  end

  assign rd        = r_rd;
  assign init_done = r_init_done;
  assign bank_err  = r_bank_err;

endmodule

// File: tb/tb_rf_banked_bypass.sv
// Bench for rf_banked_bypass: directed vector table, reset/clear sequences and
// randomized traffic against an array-based reference model.
module tb_rf_banked_bypass;
  localparam int WIDTH = 64, LG_DEPTH = 6, LG_BANKS = 1, N_RD = 6;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [N_RD*LG_DEPTH-1:0] rdptr;
  logic [N_RD*WIDTH-1:0]    rd;
  logic [1:0]               wen;
  logic [2*LG_DEPTH-1:0]    wrptr;
  logic [2*WIDTH-1:0]       wr;
  logic                     init_done;
  logic [1:0]               bank_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  wen;
    logic [5:0]  wp0, wp1;
    logic [63:0] wd0, wd1;
    logic [5:0]  rpa, rpb;
    logic [63:0] ea, eb;
    logic [1:0]  eerr;
  } vec_t;

  vec_t        tbl [10];
  logic [63:0] model [64];
  logic [63:0] exp_v [6];
  logic [5:0]  rp_v [6];

  rf_banked_bypass #(.WIDTH(WIDTH), .LG_DEPTH(LG_DEPTH), .LG_BANKS(LG_BANKS), .N_RD(N_RD)) dut (
    .clk(clk), .reset(reset), .rdptr(rdptr), .rd(rd), .wen(wen), .wrptr(wrptr),
    .wr(wr), .init_done(init_done), .bank_err(bank_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_rd(input int i, input logic [5:0] p);
    rdptr[i*LG_DEPTH +: LG_DEPTH] = p;
  endtask

  task automatic set_all_rd(input logic [5:0] p);
    for (int i = 0; i < N_RD; i++) set_rd(i, p);
  endtask

  function automatic logic [63:0] rdo(input int i);
    return rd[i*WIDTH +: WIDTH];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Release reset just after an edge and count edges to init_done.
  task automatic wait_init(input string tag);
    int early = 0;
    int rd_nz = 0;
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick;
      if (k < 32 && init_done) early++;
      if (rd !== '0) rd_nz++;
    end
    chk({tag, "_init_early"}, 64'(early), 64'd0);
    chk({tag, "_init_done"}, {63'd0, init_done}, 64'd1);
    chk({tag, "_rd_zero_in_init"}, 64'(rd_nz), 64'd0);
  endtask

  initial begin
    tbl[0] = '{2'b01, 6'd3,  6'd32, 64'h1234, 64'h0,    6'd5,  6'd0,  64'h0,    64'h0,    2'b00};
    tbl[1] = '{2'b00, 6'd3,  6'd32, 64'h0,    64'h0,    6'd3,  6'd3,  64'h1234, 64'h1234, 2'b00};
    tbl[2] = '{2'b01, 6'd0,  6'd32, 64'hFF,   64'h0,    6'd0,  6'd3,  64'h0,    64'h1234, 2'b00};
    tbl[3] = '{2'b10, 6'd1,  6'd40, 64'h0,    64'hABCD, 6'd40, 6'd40, 64'hABCD, 64'hABCD, 2'b00};
    tbl[4] = '{2'b00, 6'd1,  6'd40, 64'h0,    64'h0,    6'd40, 6'd0,  64'hABCD, 64'h0,    2'b00};
    tbl[5] = '{2'b11, 6'd10, 6'd33, 64'h111,  64'h222,  6'd10, 6'd33, 64'h111,  64'h222,  2'b00};
    tbl[6] = '{2'b00, 6'd10, 6'd33, 64'h0,    64'h0,    6'd33, 6'd10, 64'h222,  64'h111,  2'b00};
    tbl[7] = '{2'b10, 6'd1,  6'd7,  64'h0,    64'h777,  6'd7,  6'd40, 64'h0,    64'hABCD, 2'b10};
    tbl[8] = '{2'b00, 6'd1,  6'd7,  64'h0,    64'h0,    6'd7,  6'd3,  64'h0,    64'h1234, 2'b10};
    tbl[9] = '{2'b01, 6'd35, 6'd32, 64'h5,    64'h0,    6'd35, 6'd0,  64'h0,    64'h0,    2'b11};

    // Reset and clear sequence, with a write attempted during INIT.
    reset = 1'b1;
    wen   = 2'b01;
    wrptr = {6'd32, 6'd5};
    wr    = {64'h0, 64'hDEAD};
    rdptr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd", {63'd0, |rd}, 64'd0);
    chk("reset_init_done", {63'd0, init_done}, 64'd0);
    chk("reset_bank_err", {62'd0, bank_err}, 64'd0);
    set_all_rd(6'd5);
    wait_init("boot");

    // Directed vectors: each row is one cycle, outputs checked after its edge.
    for (int v = 0; v < 10; v++) begin
      wen   = tbl[v].wen;
      wrptr = {tbl[v].wp1, tbl[v].wp0};
      wr    = {tbl[v].wd1, tbl[v].wd0};
      for (int i = 0; i < N_RD; i++) set_rd(i, (i % 2 == 0) ? tbl[v].rpa : tbl[v].rpb);
      tick;
      for (int i = 0; i < N_RD; i++)
        chk($sformatf("vec%0d_rd%0d", v, i), rdo(i), (i % 2 == 0) ? tbl[v].ea : tbl[v].eb);
      chk($sformatf("vec%0d_bank_err", v), {62'd0, bank_err}, {62'd0, tbl[v].eerr});
    end

    // Sticky flag must hold; the dropped write to entry 7 stays invisible.
    begin
      int bad = 0;
      wen = 2'b00;
      set_all_rd(6'd7);
      repeat (100) begin
        tick;
        if (bank_err !== 2'b11) bad++;
      end
      chk("err_hold_100", 64'(bad), 64'd0);
      chk("err_entry7", rdo(0), 64'd0);
    end

    // Asynchronous reset clears the flag without an edge.
    #2;
    reset = 1'b1;
    #1;
    chk("async_bank_err", {62'd0, bank_err}, 64'd0);
    chk("async_init_done", {63'd0, init_done}, 64'd0);

    // Reset during INIT restarts the clear from the beginning.
    tick;
    reset = 1'b0;
    repeat (10) tick;
    reset = 1'b1;
    #2;
    tick;
    wait_init("restart");

    // Fill every entry with its index, then read some back.
    for (int k = 0; k < 32; k++) begin
      wen   = 2'b11;
      wrptr = {6'(k + 32), 6'(k)};
      wr    = {64'(k + 32), 64'(k)};
      tick;
    end
    wen = 2'b00;
    for (int i = 0; i < N_RD; i++) set_rd(i, 6'(63 - i));
    tick;
    for (int i = 0; i < N_RD; i++) chk($sformatf("fill_rd%0d", i), rdo(i), 64'(63 - i));
    chk("fill_bank_err", {62'd0, bank_err}, 64'd0);

    // Mid-operation reset between edges: outputs drop at once, storage re-cleared.
    #2;
    reset = 1'b1;
    #1;
    chk("midop_rd_clear", {63'd0, |rd}, 64'd0);
    chk("midop_init_done", {63'd0, init_done}, 64'd0);
    tick;
    wait_init("midop");
    for (int base = 0; base < 64; base += N_RD) begin
      for (int i = 0; i < N_RD; i++) set_rd(i, 6'((base + i) % 64));
      tick;
      for (int i = 0; i < N_RD; i++)
        chk($sformatf("cleared_%0d", (base + i) % 64), rdo(i), 64'd0);
    end

    // Random legal traffic against the reference model.
    for (int e = 0; e < 64; e++) model[e] = 64'd0;
    for (int c = 0; c < 10000; c++) begin
      logic [5:0]  wp0, wp1;
      logic [63:0] wd0, wd1;
      logic [1:0]  we;
      we  = 2'($urandom_range(0, 3));
      wp0 = {1'b0, 5'($urandom)};
      wp1 = {1'b1, 5'($urandom)};
      wd0 = {$urandom, $urandom};
      wd1 = {$urandom, $urandom};
      for (int i = 0; i < N_RD; i++) begin
        case ($urandom_range(0, 5))
          0:       rp_v[i] = wp0;
          1:       rp_v[i] = wp1;
          default: rp_v[i] = 6'($urandom);
        endcase
        if (rp_v[i] == 6'd0)                   exp_v[i] = 64'd0;
        else if (we[0] && rp_v[i] == wp0)      exp_v[i] = wd0;
        else if (we[1] && rp_v[i] == wp1)      exp_v[i] = wd1;
        else                                   exp_v[i] = model[rp_v[i]];
        set_rd(i, rp_v[i]);
      end
      wen   = we;
      wrptr = {wp1, wp0};
      wr    = {wd1, wd0};
      if (we[0] && wp0 != 6'd0) model[wp0] = wd0;
      if (we[1]) model[wp1] = wd1;
      tick;
      for (int i = 0; i < N_RD; i++)
        chk($sformatf("rand_c%0d_rd%0d_p%0d", c, i, rp_v[i]), rdo(i), exp_v[i]);
    end
    wen = 2'b00;
    chk("rand_bank_err", {62'd0, bank_err}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rf_banked_bypass.md
Name: rf_banked_bypass

Overview:
- Parametrised successor to the fixed 6-read/3-write banked integer physical register file.
- Generalised to N_RD read ports and N_BANKS banks, one write port per bank.
- Adds same-cycle write-to-read bypass, a hardware clear sequence after reset, and a sticky bank-violation flag in place of simulation stops.
- Sits between rename/issue (read pointers) and the per-pipe writeback buses.

Parameters:
- WIDTH, 64, data bits per entry
- LG_DEPTH, 7, log2 of total physical registers (DEPTH = 1<<LG_DEPTH)
- LG_BANKS, 1, log2 of bank count; N_BANKS = 1<<LG_BANKS; bank = ptr[LG_DEPTH-1 -: LG_BANKS]; 1 <= LG_BANKS < LG_DEPTH
- N_RD, 6, number of read ports

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rdptr  in  N_RD*LG_DEPTH  read pointers, port i at [i*LG_DEPTH +: LG_DEPTH]
- rd  out  N_RD*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
- wen  in  N_BANKS  write enable, one per bank port
- wrptr  in  N_BANKS*LG_DEPTH  write pointer per bank port
- wr  in  N_BANKS*WIDTH  write data per bank port
- init_done  out  1  high once the clear sequence has finished
- bank_err  out  N_BANKS  sticky: port b attempted a write outside bank b

Behaviour:
- Reset: asynchronous, active-high, one clock.
  - While reset is high: rd = 0, init_done = 0, bank_err = 0, FSM = INIT, clear counter = 0.
  - Storage contents are not reset asynchronously.
- Storage: N_BANKS arrays of BANK_DEPTH = DEPTH/N_BANKS entries, indexed by ptr[LG_DEPTH-LG_BANKS-1:0].
- FSM INIT:
  - Each cycle, entry[cnt] of every bank is written with 0, then cnt increments.
  - At cnt == BANK_DEPTH-1, transition to RUN. init_done rises on the next edge, i.e. BANK_DEPTH edges after reset deasserts.
  - In INIT, user writes are ignored, rd is forced to 0 and bank_err does not update.
  - Reset asserted mid-INIT restarts the clear from cnt 0.
- FSM RUN: stays in RUN until reset. There is no other exit.
- Read (RUN), latency 1 cycle: rd[i] registered from the value of rdptr[i] at the preceding edge.
  - rdptr == 0 returns 0. This overrides any write to pointer 0.
  - Bypass: if a port b has wen[b]=1, a legal bank and wrptr[b] == rdptr[i] in the same cycle, rd[i] takes wr[b] (new data).
  - Otherwise rd[i] takes the stored entry. At most one port can match, since each bank has a single writer.
  - All read ports are independent. Any number of them may address the same entry.
- Write (RUN): takes effect at the edge, so a read in the following cycle sees it.
  - Port b is legal only if the bank field of wrptr[b] equals b. An illegal write is dropped and bank_err[b] is set at that edge. It stays set until reset.
  - Writes to pointer 0 are dropped silently, with no error.
- Simultaneous events: the N_BANKS writes never collide by construction. Read and write to the same entry in the same cycle returns the new data via bypass.
- No X propagation: pointer values outside DEPTH cannot occur, because widths are exact.

Test Plan (WIDTH=64, LG_DEPTH=6, LG_BANKS=1, N_RD=6, BANK_DEPTH=32):
- Clear sequence: hold reset 3 cycles, release.
  - init_done must be 0 for 31 edges and 1 at the 32nd.
  - wen[0]=1, wrptr[0]=5, wr=0xDEAD during INIT -> dropped; after init, rdptr[0]=5 -> rd[0]=0.
- Write/read and reg 0:
  - Write wrptr[0]=3, wr[0]=0x1234 -> next cycle rdptr[2]=3 -> rd[2]=0x1234 one cycle later.
  - Write wrptr[0]=0, wr[0]=0xFF -> rdptr[0]=0 -> rd[0]=0, and bank_err stays 0.
- Bypass:
  - Same cycle: wen[1]=1, wrptr[1]=40, wr[1]=0xABCD and rdptr[0]=rdptr[5]=40 -> rd[0]=rd[5]=0xABCD next cycle.
  - Entry 40 then holds 0xABCD.
- Bank violation:
  - wen[1]=1, wrptr[1]=7 -> write dropped, bank_err=2'b10.
  - Flag remains set over 100 cycles, and a read of entry 7 is unchanged.
  - Assert reset -> bank_err=0 immediately (asynchronous).
- Reset mid-operation:
  - Fill entries 1..63 with index values, assert reset asynchronously between edges -> rd clears at once, init_done=0.
  - After release and 32 edges, all 64 entries read 0.
- Random concurrency: 10k cycles of random legal writes on both ports with 6 random reads each cycle -> rd matches a reference-model scoreboard that includes bypass.
